aibcr3_dll_dlyline_ctrl: RTL and testbench

//  Parametrised, glitch-safe controller for an NCELL-stage DLL delay line. Holds the per-cell

---
 rtl/aibcr3_dll_dlyline_ctrl_if.sv | 13 +
 rtl/aibcr3_dll_dlyline_ctrl.sv | 99 +++++++++
 tb/tb_aibcr3_dll_dlyline_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_dll_dlyline_ctrl_if.sv
// Target handshake between the DLL code logic (master) and the delay-line controller (slave).
interface aibcr3_dll_dlyline_ctrl_if #(
   parameter int NCELL = 64
);
   localparam int CODEW = $clog2(NCELL + 1);

   logic [CODEW-1:0] tgt_code;
   logic             tgt_vld;
   logic             tgt_rdy;

   modport master (output tgt_code, output tgt_vld, input tgt_rdy);
   modport slave  (input tgt_code, input tgt_vld, output tgt_rdy);
endinterface

// File: rtl/aibcr3_dll_dlyline_ctrl.sv
// DLL delay-line controller: walks a thermometer-coded cell enable vector one cell per step
// toward a requested code, with a scan path through the enable register.
module aibcr3_dll_dlyline_ctrl #(
   parameter  int NCELL  = 64,
   parameter  int SETTLE = 4,
   localparam int CODEW  = $clog2(NCELL + 1)
) (
   input  logic                     CLKIN,
   input  logic                     RST,
   aibcr3_dll_dlyline_ctrl_if.slave tgt,
   input  logic                     iSE,
   input  logic                     iSI,
   output logic                     SOOUT,
   output logic [NCELL-1:0]         bk,
   output logic [CODEW-1:0]         cur_code,
   output logic                     busy
);
   typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE, S_RESYNC} state_t;

   state_t           state;
   logic [CODEW-1:0] tgt_q;
   logic [CODEW-1:0] tgt_sat;
   logic [CODEW-1:0] pcnt;
   logic [3:0]       cnt;
   logic [NCELL-1:0] therm;

   function automatic logic [CODEW-1:0] popcount(input logic [NCELL-1:0] v);
      int sum;
      sum = 0;
      for (int i = 0; i < NCELL; i++) sum += int'(v[i]);
      return (sum > NCELL) ? CODEW'(NCELL) : CODEW'(sum);
   endfunction

   assign tgt.tgt_rdy = (state == S_IDLE) & ~iSE;
   assign SOOUT       = bk[NCELL-1];
   assign tgt_sat     = (tgt.tgt_code > CODEW'(NCELL)) ? CODEW'(NCELL) : tgt.tgt_code;

   // Scan may leave an arbitrary pattern; resync rebuilds a clean thermometer from its weight.
   always_comb begin
      pcnt = popcount(bk);
      for (int i = 0; i < NCELL; i++) therm[i] = (i < int'(pcnt));
   end

   always_ff @(posedge CLKIN) begin
      if (RST) begin
         state    <= S_IDLE;
         bk       <= '0;
         cur_code <= '0;
         tgt_q    <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
      end else if (iSE) begin
         bk    <= {bk[NCELL-2:0], iSI};
         state <= S_RESYNC;
         busy  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (tgt.tgt_vld) begin
                  tgt_q <= tgt_sat;
                  if (tgt_sat != cur_code) begin
                     state <= S_STEP;
                     busy  <= 1'b1;
                  end
               end
            end
            S_STEP: begin
               // Touch only the boundary cell so the delay never jumps by more than one stage.
               for (int i = 0; i < NCELL; i++) begin
                  if (tgt_q > cur_code && i == int'(cur_code))     bk[i] <= 1'b1;
                  if (tgt_q < cur_code && i == int'(cur_code) - 1) bk[i] <= 1'b0;
               end
               cur_code <= (tgt_q > cur_code) ? cur_code + 1'b1 : cur_code - 1'b1;
               cnt      <= 4'(SETTLE - 1);
               state    <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  if (cur_code != tgt_q) state <= S_STEP;
                  else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESYNC: begin
               cur_code <= pcnt;
               tgt_q    <= pcnt;
               bk       <= therm;
               state    <= S_IDLE;
               busy     <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aibcr3_dll_dlyline_ctrl.sv
// Randomised bench for the delay-line controller against a timeline-based reference model.
module tb_aibcr3_dll_dlyline_ctrl;
   localparam int N = 64;
   localparam int S = 4;

   logic        CLKIN = 1'b0;
   logic        RST;
   logic        ise;
   logic        isi;
   logic        SOOUT;
   logic        busy;
   logic [63:0] bk;
   logic [6:0]  cur_code;
   logic        chk_en = 1'b0;
   logic [63:0] prev_bk;
   int          checks = 0;
   int          errors = 0;

   always #5 CLKIN = ~CLKIN;

   aibcr3_dll_dlyline_ctrl_if #(.NCELL(N)) tif();

   aibcr3_dll_dlyline_ctrl #(.NCELL(N), .SETTLE(S)) dut (
      .CLKIN(CLKIN), .RST(RST), .tgt(tif), .iSE(ise), .iSI(isi),
      .SOOUT(SOOUT), .bk(bk), .cur_code(cur_code), .busy(busy)
   );

   // Model: a move of d cells accepted at edge 0 applies step j at edge 1+(j-1)*(S+1)
   // and finishes at edge d*(S+1); scan shifts raw bits, then one resync edge.
   typedef struct {
      logic [63:0] bk;
      int cur, tgt, cur0, d, t;
      bit moving, resync, busy, bulk;
   } mstate_t;

   mstate_t m;

   function automatic logic [63:0] therm(input int c);
      return (c >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << c) - 64'd1);
   endfunction

   function automatic int lowbit(input logic [63:0] v);
      for (int i = 0; i < 64; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic mstate_t model_next(input mstate_t s, input bit r, input bit v,
                                          input int code, input bit se, input bit si);
      mstate_t n;
      int steps;
      n = s;
      n.bulk = 1'b0;
      if (r) begin
         n.bk = '0; n.cur = 0; n.tgt = 0; n.moving = 0; n.resync = 0; n.busy = 0; n.bulk = 1;
      end else if (se) begin
         n.bk = {s.bk[62:0], si}; n.moving = 0; n.resync = 1; n.busy = 1; n.bulk = 1;
      end else if (s.resync) begin
         n.cur = $countones(s.bk); n.tgt = n.cur; n.bk = therm(n.cur);
         n.resync = 0; n.busy = 0; n.bulk = 1;
      end else if (s.moving) begin
         n.t = s.t + 1;
         steps = (n.t - 1) / (S + 1) + 1;
         if (steps > s.d) steps = s.d;
         n.cur = (s.tgt > s.cur0) ? s.cur0 + steps : s.cur0 - steps;
         n.bk = therm(n.cur);
         if (n.t == s.d * (S + 1)) begin n.moving = 0; n.busy = 0; end
      end else if (v) begin
         n.tgt = (code > N) ? N : code;
         if (n.tgt != s.cur) begin
            n.moving = 1; n.t = 0; n.cur0 = s.cur; n.busy = 1;
            n.d = (n.tgt > s.cur) ? n.tgt - s.cur : s.cur - n.tgt;
         end
      end
      return n;
   endfunction

   always @(posedge CLKIN) m <= model_next(m, RST, tif.tgt_vld, int'(tif.tgt_code), ise, isi);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLKIN) begin
      if (chk_en) begin
         chk("cur_code", 64'(cur_code), 64'(m.cur));
         chk("bk", bk, m.bk);
         chk("busy", 64'(busy), 64'(m.busy));
         chk("soout", 64'(SOOUT), 64'(m.bk[63]));
         chk("tgt_rdy", 64'(tif.tgt_rdy), 64'(!m.busy && !ise));
         if (!m.bulk) chk("onebit", 64'($countones(bk ^ prev_bk) <= 1), 64'd1);
      end
      prev_bk <= bk;
   end

   task automatic tick;
      @(posedge CLKIN);
      #1;
   endtask

   task automatic wait_idle;
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLKIN);
         if (!busy) break;
      end
      chk("idle_timeout", 64'(busy), 64'd0);
      tick;
   endtask

   task automatic move(input int code, output int nb, output int nchg, output int first,
                       output int last);
      logic [63:0] prev;
      nb = 0; nchg = 0; first = -1; last = -1;
      tif.tgt_vld = 1'b1;
      tif.tgt_code = 7'(code);
      tick;
      tif.tgt_vld = 1'b0;
      prev = bk;
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLKIN);
         if (bk !== prev) begin
            nchg++;
            if (first < 0) first = lowbit(bk ^ prev);
            last = lowbit(bk ^ prev);
            prev = bk;
         end
         if (!busy) break;
         nb++;
      end
      chk("move_timeout", 64'(busy), 64'd0);
      tick;
   endtask

   task automatic scan_rand(input int len);
      for (int i = 0; i < len; i++) begin
         ise = 1'b1;
         isi = 1'($urandom % 2);
         tick;
      end
      ise = 1'b0;
   endtask

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nchg, first, last, c, op;
      logic [63:0] pat, prior;
      RST = 1'b1; ise = 1'b0; isi = 1'b0;
      tif.tgt_vld = 1'b0; tif.tgt_code = '0;
      tick; tick;
      RST = 1'b0;
      chk_en = 1'b1;
      @(negedge CLKIN);
      chk("rst_cur", 64'(cur_code), 64'd0);
      chk("rst_bk", bk, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_soout", 64'(SOOUT), 64'd0);
      tick;

      move(10, nb, nchg, first, last);
      chk("t1_busy_cycles", 64'(nb), 64'd50);
      chk("t1_steps", 64'(nchg), 64'd10);
      chk("t1_cur", 64'(cur_code), 64'd10);
      chk("t1_bk", bk, 64'h3FF);

      move(3, nb, nchg, first, last);
      chk("t2_busy_cycles", 64'(nb), 64'd35);
      chk("t2_first_bit", 64'(first), 64'd9);
      chk("t2_last_bit", 64'(last), 64'd3);
      chk("t2_bk", bk, 64'h7);

      move(100, nb, nchg, first, last);
      chk("t3_busy_cycles", 64'(nb), 64'd305);
      chk("t3_cur", 64'(cur_code), 64'd64);
      chk("t3_bk", bk, 64'hFFFF_FFFF_FFFF_FFFF);

      move(20, nb, nchg, first, last);
      chk("t4_pre_bk", bk, 64'hF_FFFF);

      pat = 64'hA5A5_A5A5_A5A5_A5A5;
      prior = 64'hF_FFFF;
      for (int i = 0; i < 64; i++) begin
         ise = 1'b1;
         isi = pat[63-i];
         @(negedge CLKIN);
         chk("t4_soout", 64'(SOOUT), 64'(prior[63-i]));
         tick;
      end
      ise = 1'b0;
      @(negedge CLKIN);
      chk("t4_scanned_bk", bk, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("t4_resync_busy", 64'(busy), 64'd1);
      tick;
      @(negedge CLKIN);
      chk("t4_cur", 64'(cur_code), 64'd32);
      chk("t4_bk", bk, 64'hFFFF_FFFF);
      chk("t4_busy", 64'(busy), 64'd0);
      tick;

      move(5, nb, nchg, first, last);
      chk("t5_pre_cycles", 64'(nb), 64'd135);
      tif.tgt_vld = 1'b1; tif.tgt_code = 7'd20;
      tick;
      tif.tgt_vld = 1'b0;
      repeat (7) tick;
      for (int i = 0; i < 8; i++) begin
         ise = 1'b1; isi = 1'b1;
         tick;
      end
      ise = 1'b0;
      @(negedge CLKIN);
      chk("t5_frozen_cur", 64'(cur_code), 64'd7);
      chk("t5_busy", 64'(busy), 64'd1);
      tick;
      @(negedge CLKIN);
      chk("t5_cur", 64'(cur_code), 64'd15);
      chk("t5_bk", bk, 64'h7FFF);
      chk("t5_busy_fell", 64'(busy), 64'd0);
      repeat (10) tick;
      chk("t5_aborted", 64'(cur_code), 64'd15);
      move(15, nb, nchg, first, last);
      chk("t5_tgtq_zero_step", 64'(nb), 64'd0);

      tif.tgt_vld = 1'b1; tif.tgt_code = 7'd30;
      tick;
      tif.tgt_vld = 1'b0;
      repeat (3) tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      tif.tgt_vld = 1'b1; tif.tgt_code = 7'd4;
      @(negedge CLKIN);
      chk("t6_bk", bk, 64'd0);
      chk("t6_cur", 64'(cur_code), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_rdy", 64'(tif.tgt_rdy), 64'd1);
      tick;
      tif.tgt_vld = 1'b0;
      @(negedge CLKIN);
      chk("t6_reaccept", 64'(busy), 64'd1);
      wait_idle;
      chk("t6_final_bk", bk, 64'hF);

      for (int n = 0; n < 150; n++) begin
         op = int'($urandom % 10);
         if (op < 4) begin
            if (op == 0) c = int'($urandom_range(0, 127));
            else c = m.cur + int'($urandom_range(0, 16)) - 8;
            if (c < 0) c = 0;
            if (c > 127) c = 127;
            tif.tgt_vld = 1'b1; tif.tgt_code = 7'(c);
            tick;
            tif.tgt_vld = 1'b0;
            if ($urandom % 4 == 0) begin
               repeat ($urandom_range(0, 20)) tick;
               scan_rand(int'($urandom_range(1, 70)));
            end
            wait_idle;
         end else if (op < 7) begin
            scan_rand(int'($urandom_range(1, 70)));
            wait_idle;
         end else if (op == 7) begin
            tif.tgt_vld = 1'b1; tif.tgt_code = 7'($urandom_range(0, 127));
            tick;
            tif.tgt_vld = 1'b0;
            repeat ($urandom_range(0, 30)) tick;
            RST = 1'b1;
            tick;
            RST = 1'b0;
            wait_idle;
         end else begin
            repeat ($urandom_range(1, 20)) begin
               tif.tgt_vld = ($urandom % 3 == 0);
               tif.tgt_code = 7'($urandom_range(0, 127));
               tick;
            end
            tif.tgt_vld = 1'b0;
            wait_idle;
         end
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
